writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM->WB stage sitting directly upstream of the register file write port (rd/dataIn/regWrite).
//  Formats load data (LW/LB/LBU/LH/LHU), selects ALU vs memory result and buffers retiring
//  instructions in a small FIFO. It issues one register-file write per cycle unless held by wbHold.
// PARAMETERS
//  DATA_W   32  datapath width
//  ADDR_W   5   register index width
//  DEPTH    2   FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  inValid      in   1       upstream instruction valid
//  inReady      out  1       stage can accept (= FIFO not full)
//  inRd         in   ADDR_W  destination register
//  inRegWrite   in   1       instruction writes a register
//  inMemToReg   in   1       1: load data, 0: aluResult
//  inLoadType   in   3       000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others=LW
//  inByteOff    in   2       address[1:0] of the load
//  aluResult    in   DATA_W  ALU result
//  memData      in   DATA_W  raw data-memory word
//  wbHold       in   1       freeze write issue (hazard/debug)
//  rd           out  ADDR_W  to register file rd
//  dataIn       out  DATA_W  to register file dataIn
//  regWrite     out  1       to register file regWrite, one-cycle pulse per write
//  alignErr     out  1       one-cycle pulse: misaligned halfword/word load accepted
//  retireCount  out  16      count of dequeued entries, wraps at 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, pointers/count=0; rd, dataIn, regWrite, alignErr, retireCount=0;
//   inReady=1 once out of reset. A mid-operation reset drops all entries and deasserts regWrite at once.
//  Accept: inValid&&inReady at an edge enqueues {rd, we, data}. inReady=!full, with no same-cycle
//   dequeue credit.
//  Data formatting at enqueue (little-endian byte lanes):
//   LB/LBU: byte = memData[8*inByteOff +: 8], sign-/zero-extended to DATA_W.
//   LH/LHU: half = memData[16*inByteOff[1] +: 16]; inByteOff[0]=1 -> misaligned.
//   LW: inByteOff!=0 -> misaligned.
//   Misaligned load: entry stored with we=0; alignErr pulses the cycle after accept.
//   inMemToReg=0: data=aluResult and inLoadType/inByteOff are ignored.
//  Stored we = inRegWrite && (inRd!=0) && !misaligned.
//  FIFO states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Pointers wrap modulo DEPTH.
//  Issue: at each edge where !wbHold and count>0, the head is dequeued into the output registers:
//   regWrite<=head.we, rd<=head.rd, dataIn<=head.data, retireCount++.
//   Otherwise regWrite<=0 and rd/dataIn hold their values.
//  Latency: accept at edge N -> outputs valid after edge N+1 -> register file writes at edge N+2.
//   Throughput 1/cycle when wbHold=0.
//  Simultaneous enqueue+dequeue: both happen and count is unchanged. When FULL, no enqueue that cycle.
//  wbHold=1: no dequeue, regWrite=0, FIFO keeps filling until FULL, then inReady=0.
//  Order preserved: writes issue in acceptance order, including entries with we=0.
// CONFIGURATION
//  WB_FWD_EN defined: adds ports fwdRs in ADDR_W, fwdHit out 1, fwdData out DATA_W (combinational).
//   Lookup covers the output register (if regWrite=1) and all FIFO entries with we=1 and rd==fwdRs.
//   The youngest match wins: FIFO tail-most entry first, then output register.
//   fwdRs=0 -> fwdHit=0. No match -> fwdHit=0, fwdData=0. During reset both are 0.
//  WB_FWD_EN undefined: those ports and the lookup logic do not exist; all other behaviour is identical.
// TESTING
//  1. ALU op rd=9, aluResult=0x0000000A, wbHold=0 -> after 2 edges regWrite=1, rd=9, dataIn=0x0A for 1 cycle.
//  2. memData=0x80FF7F01, LB off=3 -> dataIn=0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF.
//  3. LHU off=1 -> alignErr pulse, entry retires with regWrite=0, retireCount+1. LW off=2 -> same.
//  4. wbHold=1, push 3 entries (DEPTH=2) -> inReady=0 after 2 accepts; release hold ->
//     writes issue in order, 1 per cycle.
//  5. inRd=0, inRegWrite=1 -> regWrite stays 0. Assert rst_n=0 while FULL -> immediately regWrite=0,
//     inReady=1 after release, no stale writes.
//  6. WB_FWD_EN, FIFO holds rd=10 (old) then rd=10 (new), fwdRs=10 -> fwdHit=1, fwdData=new value.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM->WB stage: formats load data, picks ALU/memory result, buffers retiring
// instructions in a small FIFO and issues one register-file write per cycle. Optional forwarding: WB_FWD_EN.
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    output logic              inReady,
    input  logic [ADDR_W-1:0] inRd,
    input  logic              inRegWrite,
    input  logic              inMemToReg,
    input  logic [2:0]        inLoadType,
    input  logic [1:0]        inByteOff,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memData,
    input  logic              wbHold,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] dataIn,
    output logic              regWrite,
    output logic              alignErr,
`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0] fwdRs,
    output logic              fwdHit,
    output logic [DATA_W-1:0] fwdData,
`endif
    output logic [15:0]       retireCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifoState_t;

    logic [ADDR_W-1:0] r_rdMem   [DEPTH];
    logic              r_weMem   [DEPTH];
    logic [DATA_W-1:0] r_dataMem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_dataIn;
    logic              r_regWrite;
    logic              r_alignErr;
    logic [15:0]       r_retireCount;

    fifoState_t        w_state;
    logic              w_enq;
    logic              w_deq;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_data;
    logic              w_misaligned;
    logic              w_we;

    always_comb begin
        if (r_count == '0)
            w_state = EMPTY;
        else if (r_count == CNT_W'(DEPTH))
            w_state = FULL;
        else
            w_state = PARTIAL;
    end

    assign inReady = (w_state != FULL);
    assign w_enq   = inValid && (w_state != FULL);
    assign w_deq   = !wbHold && (w_state != EMPTY);

    // Unknown load types behave as LW; ALU results never raise a misalignment.
    always_comb begin
        w_byte       = memData[{inByteOff, 3'b000} +: 8];
        w_half       = memData[{inByteOff[1], 4'b0000} +: 16];
        w_data       = aluResult;
        w_misaligned = 1'b0;
        if (inMemToReg) begin
            case (inLoadType)
                3'b001:  w_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
                3'b010:  w_data = {{(DATA_W-8){1'b0}}, w_byte};
                3'b011: begin
                    w_data       = {{(DATA_W-16){w_half[15]}}, w_half};
                    w_misaligned = inByteOff[0];
                end
                3'b100: begin
                    w_data       = {{(DATA_W-16){1'b0}}, w_half};
                    w_misaligned = inByteOff[0];
                end
                default: begin
                    w_data       = memData;
                    w_misaligned = (inByteOff != 2'b00);
                end
            endcase
        end
        w_we = inRegWrite && (inRd != '0) && !w_misaligned;
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_rdMem[r_tail]   <= inRd;
            r_weMem[r_tail]   <= w_we;
            r_dataMem[r_tail] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_rd          <= '0;
            r_dataIn      <= '0;
            r_regWrite    <= 1'b0;
            r_alignErr    <= 1'b0;
            r_retireCount <= '0;
        end else begin
            r_alignErr <= w_enq && w_misaligned;
            if (w_enq)
                r_tail <= r_tail + 1'b1;
            if (w_deq) begin
                r_head        <= r_head + 1'b1;
                r_regWrite    <= r_weMem[r_head];
                r_rd          <= r_rdMem[r_head];
                r_dataIn      <= r_dataMem[r_head];
                r_retireCount <= r_retireCount + 16'd1;
            end else begin
                r_regWrite <= 1'b0;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd          = r_rd;
    assign dataIn      = r_dataIn;
    assign regWrite    = r_regWrite;
    assign alignErr    = r_alignErr;
    assign retireCount = r_retireCount;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the tail-most match overrides earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        fwdHit  = 1'b0;
        fwdData = '0;
        if (rst_n && (fwdRs != '0)) begin
            if (r_regWrite && (r_rd == fwdRs)) begin
                fwdHit  = 1'b1;
                fwdData = r_dataIn;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_head + PTR_W'(i);
                if ((CNT_W'(i) < r_count) && r_weMem[idx] && (r_rdMem[idx] == fwdRs)) begin
                    fwdHit  = 1'b1;
                    fwdData = r_dataMem[idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage against a queue-based reference model.
module tb_writeback_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  inRd;
    logic        inRegWrite;
    logic        inMemToReg;
    logic [2:0]  inLoadType;
    logic [1:0]  inByteOff;
    logic [31:0] aluResult;
    logic [31:0] memData;
    logic        wbHold;
    logic [4:0]  rd;
    logic [31:0] dataIn;
    logic        regWrite;
    logic        alignErr;
    logic [15:0] retireCount;
`ifdef WB_FWD_EN
    logic [4:0]  fwdRs;
    logic        fwdHit;
    logic [31:0] fwdData;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } entry_t;
    entry_t q[$];

    logic        expRegWrite, expAlignErr, expInReady, sampledInReady;
    logic [4:0]  expRd;
    logic [31:0] expData;
    logic [15:0] expRetire;

    logic [2:0]  loadType [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [1:0]  loadOff  [5] = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd2};
    logic [31:0] loadExp  [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h0, 32'h0};
    logic        loadErr  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    writeback_stage #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .inRd(inRd),
        .inRegWrite(inRegWrite), .inMemToReg(inMemToReg), .inLoadType(inLoadType),
        .inByteOff(inByteOff), .aluResult(aluResult), .memData(memData), .wbHold(wbHold),
        .rd(rd), .dataIn(dataIn), .regWrite(regWrite), .alignErr(alignErr),
`ifdef WB_FWD_EN
        .fwdRs(fwdRs), .fwdHit(fwdHit), .fwdData(fwdData),
`endif
        .retireCount(retireCount)
    );

    always #5 clk = ~clk;

    // Load formatting from the byte-lane rules, using shifts and masks
    function automatic void formatLoad(input logic m2r, input logic [2:0] lt, input logic [1:0] off,
                                       input logic [31:0] alu, input logic [31:0] mem,
                                       output logic [31:0] d, output logic mis);
        logic [31:0] b, h;
        mis = 1'b0;
        d   = alu;
        if (m2r) begin
            b = (mem >> (8 * int'(off))) & 32'hFF;
            h = (mem >> (16 * (int'(off) / 2))) & 32'hFFFF;
            if (lt == 3'd1)      d = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            else if (lt == 3'd2) d = b;
            else if (lt == 3'd3) begin d = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h; mis = (int'(off) % 2) == 1; end
            else if (lt == 3'd4) begin d = h; mis = (int'(off) % 2) == 1; end
            else begin d = mem; mis = (off != 2'd0); end
        end
    endfunction

    function automatic void modelReset();
        q.delete();
        expRegWrite = 1'b0; expAlignErr = 1'b0; expRd = '0; expData = '0; expRetire = '0;
    endfunction

    // Drives one cycle of inputs and advances the model across the rising edge
    task automatic applyStimulus(input logic v, input logic [4:0] r, input logic rw, input logic m2r,
                                 input logic [2:0] lt, input logic [1:0] off, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic hold);
        logic [31:0] d;
        logic        mis;
        logic        accept;
        entry_t      e;
        @(negedge clk);
        inValid = v; inRd = r; inRegWrite = rw; inMemToReg = m2r; inLoadType = lt;
        inByteOff = off; aluResult = alu; memData = mem; wbHold = hold;
        #1 sampledInReady = inReady;
        expInReady = (q.size() < DEPTH);
        formatLoad(m2r, lt, off, alu, mem, d, mis);
        accept = v && expInReady;
        @(posedge clk);
        if (!hold && q.size() > 0) begin
            e = q.pop_front();
            expRegWrite = e.we; expRd = e.rd; expData = e.data; expRetire = expRetire + 16'd1;
        end else begin
            expRegWrite = 1'b0;
        end
        expAlignErr = accept && mis;
        if (accept) q.push_back('{rd: r, we: rw && (r != 5'd0) && !mis, data: d});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inValid = 0; inRd = 0; inRegWrite = 0; inMemToReg = 0; inLoadType = 0;
        inByteOff = 0; aluResult = 0; memData = 0; wbHold = 0;
`ifdef WB_FWD_EN
        fwdRs = 5'd0;
`endif
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (regWrite !== 1'b0 || rd !== 5'd0 || dataIn !== 32'd0 || alignErr !== 1'b0 || retireCount !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got regWrite=%b rd=%0d dataIn=%h alignErr=%b retire=%0d, want all 0",
                     regWrite, rd, dataIn, alignErr, retireCount);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_inReady: got %b want 1", inReady);
        end
    endtask

    task automatic test_alu();
        applyStimulus(1, 5'd9, 1, 0, 0, 0, 32'h0000000A, 32'hDEADBEEF, 0);
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alu_edge1: regWrite got %b want 0", regWrite);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd9 || dataIn !== 32'h0000000A) begin
            failures++;
            $display("[TB] FAIL alu_write: got regWrite=%b rd=%0d dataIn=%h want 1/9/0000000a", regWrite, rd, dataIn);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (regWrite !== 1'b0 || retireCount !== expRetire) begin
            failures++;
            $display("[TB] FAIL alu_pulse: got regWrite=%b retire=%0d want 0/%0d", regWrite, retireCount, expRetire);
        end
    endtask

    task automatic test_loads();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5'd5, 1, 1, loadType[i], loadOff[i], 32'h12345678, 32'h80FF7F01, 0);
            checks++;
            if (alignErr !== loadErr[i] || alignErr !== expAlignErr) begin
                failures++;
                $display("[TB] FAIL load%0d_alignErr: got %b want %b", i, alignErr, loadErr[i]);
            end
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (regWrite !== !loadErr[i] || alignErr !== 1'b0 || retireCount !== expRetire) begin
                failures++;
                $display("[TB] FAIL load%0d_retire: got regWrite=%b alignErr=%b retire=%0d want %b/0/%0d",
                         i, regWrite, alignErr, retireCount, !loadErr[i], expRetire);
            end
            if (!loadErr[i]) begin
                checks++;
                if (dataIn !== loadExp[i] || dataIn !== expData) begin
                    failures++;
                    $display("[TB] FAIL load%0d_data: got %h want %h", i, dataIn, loadExp[i]);
                end
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'(i + 1), 1, 0, 0, 0, 32'hA0 + 32'(i), 0, 1);
            checks++;
            if (sampledInReady !== (i < 2) || regWrite !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold_fill%0d: got inReady=%b regWrite=%b want %b/0", i, sampledInReady, regWrite, i < 2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (regWrite !== (i < 2) || (i < 2 && (rd !== 5'(i + 1) || dataIn !== 32'hA0 + 32'(i)))) begin
                failures++;
                $display("[TB] FAIL hold_drain%0d: got regWrite=%b rd=%0d dataIn=%h want %b/%0d/%h",
                         i, regWrite, rd, dataIn, i < 2, i + 1, 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_rd0_and_reset();
        applyStimulus(1, 5'd0, 1, 0, 0, 0, 32'h55, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (regWrite !== 1'b0 || retireCount !== expRetire) begin
            failures++;
            $display("[TB] FAIL rd0: got regWrite=%b retire=%0d want 0/%0d", regWrite, retireCount, expRetire);
        end
        applyStimulus(1, 5'd3, 1, 0, 0, 0, 32'h33, 0, 1);
        applyStimulus(1, 5'd4, 1, 0, 0, 0, 32'h44, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (sampledInReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_inReady: got %b want 0", sampledInReady);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (regWrite !== 1'b1 || rd !== 5'd3) begin
            failures++;
            $display("[TB] FAIL prereset_write: got regWrite=%b rd=%0d want 1/3", regWrite, rd);
        end
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checks++;
        if (regWrite !== 1'b0 || retireCount !== 16'd0 || inReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset: got regWrite=%b retire=%0d inReady=%b want 0/0/1", regWrite, retireCount, inReady);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (regWrite !== 1'b0 || sampledInReady !== 1'b1) begin
                failures++;
                $display("[TB] FAIL postreset%0d: got regWrite=%b inReady=%b want 0/1", i, regWrite, sampledInReady);
            end
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        applyStimulus(1, 5'd10, 1, 0, 0, 0, 32'h0111, 0, 1);
        applyStimulus(1, 5'd10, 1, 0, 0, 0, 32'h0222, 0, 1);
        fwdRs = 5'd10;
        #1;
        checks++;
        if (fwdHit !== 1'b1 || fwdData !== 32'h0222) begin
            failures++;
            $display("[TB] FAIL fwd_youngest: got hit=%b data=%h want 1/00000222", fwdHit, fwdData);
        end
        fwdRs = 5'd0;
        #1;
        checks++;
        if (fwdHit !== 1'b0 || fwdData !== 32'd0) begin
            failures++;
            $display("[TB] FAIL fwd_rs0: got hit=%b data=%h want 0/0", fwdHit, fwdData);
        end
        idle(3);
    endtask
`endif

    task automatic test_random();
        logic [31:0] fd;
        logic        fh;
        for (int n = 0; n < 400; n++) begin
`ifdef WB_FWD_EN
            fwdRs = 5'($urandom_range(0, 7));
`endif
            applyStimulus($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                          3'($urandom_range(0, 5)), 2'($urandom), $urandom, $urandom, $urandom_range(0, 3) == 0);
            checks++;
            if (sampledInReady !== expInReady || regWrite !== expRegWrite || rd !== expRd || dataIn !== expData ||
                alignErr !== expAlignErr || retireCount !== expRetire) begin
                failures++;
                $display("[TB] FAIL rand%0d: got rdy=%b we=%b rd=%0d d=%h ae=%b rc=%0d want %b/%b/%0d/%h/%b/%0d",
                         n, sampledInReady, regWrite, rd, dataIn, alignErr, retireCount,
                         expInReady, expRegWrite, expRd, expData, expAlignErr, expRetire);
            end
`ifdef WB_FWD_EN
            fh = 1'b0; fd = '0;
            if (fwdRs != 5'd0) begin
                if (expRegWrite && expRd == fwdRs) begin fh = 1'b1; fd = expData; end
                foreach (q[k]) if (q[k].we && q[k].rd == fwdRs) begin fh = 1'b1; fd = q[k].data; end
            end
            checks++;
            if (fwdHit !== fh || fwdData !== fd) begin
                failures++;
                $display("[TB] FAIL rand%0d_fwd: got hit=%b data=%h want %b/%h", n, fwdHit, fwdData, fh, fd);
            end
`else
            fh = 1'b0; fd = '0;
`endif
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        idle(2);
        test_hold();
        test_rd0_and_reset();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
